// File: rtl/cv32e41p_tb_mem_arbiter.sv
// Round-robin arbiter that merges the OBI fetch and data ports onto one single-port, 1-cycle RAM.
// Optional macro TB_ARB_STALL_EN adds an LFSR that injects deterministic grant stalls.
module cv32e41p_tb_mem_arbiter #(
    parameter int unsigned RAM_ADDR_WIDTH = 22
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      instr_req_i,
    output logic                      instr_gnt_o,
    input  logic [31:0]               instr_addr_i,
    output logic                      instr_rvalid_o,
    output logic [31:0]               instr_rdata_o,

    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [31:0]               data_addr_i,
    input  logic [31:0]               data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [31:0]               data_rdata_o,

    output logic                      ram_en_o,
    output logic                      ram_we_o,
    output logic [3:0]                ram_be_o,
    output logic [RAM_ADDR_WIDTH-3:0] ram_addr_o,
    output logic [31:0]               ram_wdata_o,
    input  logic [31:0]               ram_rdata_i
);

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    port_e last_q, last_d;
    port_e resp_owner_q, resp_owner_d;
    logic  resp_valid_q, resp_valid_d;
    logic  gnt_instr, gnt_data;
    logic  stall;

`ifdef TB_ARB_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; a 00 in the low bits blocks all grants this cycle.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        gnt_instr    = 1'b0;
        gnt_data     = 1'b0;
        ram_en_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_be_o     = 4'h0;
        ram_addr_o   = '0;
        ram_wdata_o  = '0;
        last_d       = last_q;
        resp_valid_d = 1'b0;
        resp_owner_d = resp_owner_q;

        // On a tie the port that did not win last time gets the RAM.
        if (!stall) begin
            if (instr_req_i && data_req_i) begin
                if (last_q == PORT_INSTR) begin
                    gnt_data = 1'b1;
                end else begin
                    gnt_instr = 1'b1;
                end
            end else begin
                gnt_instr = instr_req_i;
                gnt_data  = data_req_i;
            end
        end

        if (gnt_instr) begin
            ram_en_o     = 1'b1;
            ram_be_o     = 4'hF;
            ram_addr_o   = instr_addr_i[RAM_ADDR_WIDTH-1:2];
            last_d       = PORT_INSTR;
            resp_valid_d = 1'b1;
            resp_owner_d = PORT_INSTR;
        end else if (gnt_data) begin
            ram_en_o     = 1'b1;
            ram_we_o     = data_we_i;
            ram_be_o     = data_be_i;
            ram_addr_o   = data_addr_i[RAM_ADDR_WIDTH-1:2];
            ram_wdata_o  = data_wdata_i;
            last_d       = PORT_DATA;
            resp_valid_d = 1'b1;
            resp_owner_d = PORT_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q       <= PORT_INSTR;
            resp_valid_q <= 1'b0;
            resp_owner_q <= PORT_INSTR;
        end else begin
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    assign instr_gnt_o    = gnt_instr;
    assign data_gnt_o     = gnt_data;
    assign instr_rvalid_o = resp_valid_q && (resp_owner_q == PORT_INSTR);
    assign data_rvalid_o  = resp_valid_q && (resp_owner_q == PORT_DATA);
    assign instr_rdata_o  = ram_rdata_i;
    assign data_rdata_o   = ram_rdata_i;

    // Address bits outside the RAM window alias and the low byte-offset bits are meaningless.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[31:RAM_ADDR_WIDTH], instr_addr_i[1:0],
                                data_addr_i[31:RAM_ADDR_WIDTH], data_addr_i[1:0]};

endmodule

// File: tb/tb_cv32e41p_tb_mem_arbiter.sv
// Self-checking bench for cv32e41p_tb_mem_arbiter: directed and random traffic against a behavioural model.
// Honours TB_ARB_STALL_EN the same way the design does.
module tb_cv32e41p_tb_mem_arbiter;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_req_i = 1'b0;
    logic          instr_gnt_o;
    logic [31:0]   instr_addr_i = '0;
    logic          instr_rvalid_o;
    logic [31:0]   instr_rdata_o;
    logic          data_req_i = 1'b0;
    logic          data_gnt_o;
    logic          data_we_i = 1'b0;
    logic [3:0]    data_be_i = '0;
    logic [31:0]   data_addr_i = '0;
    logic [31:0]   data_wdata_i = '0;
    logic          data_rvalid_o;
    logic [31:0]   data_rdata_o;
    logic          ram_en_o;
    logic          ram_we_o;
    logic [3:0]    ram_be_o;
    logic [AW-3:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic [31:0]   ram_rdata_i = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cv32e41p_tb_mem_arbiter #(.RAM_ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .ram_en_o       (ram_en_o),
        .ram_we_o       (ram_we_o),
        .ram_be_o       (ram_be_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_rdata_i    (ram_rdata_i)
    );

    function automatic logic [31:0] mergeBytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Single-port write-first RAM with one cycle of read latency
    logic [31:0] mem [4096];
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                mem[ram_addr_o[11:0]] <= mergeBytes(mem[ram_addr_o[11:0]], ram_wdata_o, ram_be_o);
                ram_rdata_i <= mergeBytes(mem[ram_addr_o[11:0]], ram_wdata_o, ram_be_o);
            end else begin
                ram_rdata_i <= mem[ram_addr_o[11:0]];
            end
        end
    end

    // Behavioural model state
    logic [31:0] ref_mem [4096];
    logic        m_last_data;
    logic        m_pv;
    logic        m_pown_data;
    logic        m_pwrite;
    logic [31:0] m_pdata;
    logic [7:0]  m_lfsr;
    logic        e_gi, e_gd;

    task automatic resetModel();
        m_last_data = 1'b0;
        m_pv        = 1'b0;
        m_pown_data = 1'b0;
        m_pwrite    = 1'b0;
        m_pdata     = '0;
        m_lfsr      = 8'hA5;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic reportTimeout(input string tag);
        n_checks++;
        n_errors++;
        $error("[TB] FAIL %s: observed no grant within 8 cycles, expected a grant", tag);
    endtask

    // One clock cycle: drive inputs, check every output against the model, then advance the model.
    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                 input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd);
        logic        stall;
        logic [31:0] a;
        logic [31:0] e_addr;
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_we_i    = dw;
        data_be_i    = dbe;
        data_addr_i  = da;
        data_wdata_i = dwd;
        #1;
`ifdef TB_ARB_STALL_EN
        stall = (m_lfsr[1:0] == 2'b00);
`else
        stall = 1'b0;
`endif
        e_gi = 1'b0;
        e_gd = 1'b0;
        if (!stall) begin
            if (ir && dr) begin
                if (m_last_data) e_gi = 1'b1;
                else             e_gd = 1'b1;
            end else begin
                e_gi = ir;
                e_gd = dr;
            end
        end
        a      = e_gi ? ia : da;
        e_addr = (e_gi || e_gd) ? {12'h0, a[AW-1:2]} : 32'h0;
        checkOutput("instr_gnt", 32'(instr_gnt_o), 32'(e_gi));
        checkOutput("data_gnt", 32'(data_gnt_o), 32'(e_gd));
        checkOutput("ram_en", 32'(ram_en_o), 32'(e_gi || e_gd));
        checkOutput("ram_we", 32'(ram_we_o), 32'(e_gd && dw));
        checkOutput("ram_be", 32'(ram_be_o), e_gi ? 32'hF : (e_gd ? 32'(dbe) : 32'h0));
        checkOutput("ram_addr", 32'(ram_addr_o), e_addr);
        checkOutput("ram_wdata", ram_wdata_o, e_gd ? dwd : 32'h0);
        checkOutput("instr_rvalid", 32'(instr_rvalid_o), 32'(m_pv && !m_pown_data));
        checkOutput("data_rvalid", 32'(data_rvalid_o), 32'(m_pv && m_pown_data));
        if (m_pv && !m_pwrite) begin
            if (m_pown_data) checkOutput("data_rdata", data_rdata_o, m_pdata);
            else             checkOutput("instr_rdata", instr_rdata_o, m_pdata);
        end
        @(posedge clk);
        if (e_gi || e_gd) begin
            m_pdata     = ref_mem[a[13:2]];
            m_pwrite    = e_gd && dw;
            m_pown_data = e_gd;
            m_last_data = e_gd;
            m_pv        = 1'b1;
            if (e_gd && dw) ref_mem[a[13:2]] = mergeBytes(ref_mem[a[13:2]], dwd, dbe);
        end else begin
            m_pv = 1'b0;
        end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        @(negedge clk);
    endtask

    task automatic doInstr(input logic [31:0] a);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, a, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            if (e_gi) return;
        end
        reportTimeout("instr_wait");
    endtask

    task automatic doData(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, we, be, a, wd);
            if (e_gd) return;
        end
        reportTimeout("data_wait");
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    logic        p_i, p_d, p_we;
    logic [31:0] p_ia, p_da, p_wd;
    logic [3:0]  p_be;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = i * 32'h9E3779B9;
            ref_mem[i] = i * 32'h9E3779B9;
        end
        mem[12'h060]     = 32'h00000013;
        ref_mem[12'h060] = 32'h00000013;
        mem[12'h400]     = 32'h11223344;
        ref_mem[12'h400] = 32'h11223344;
        resetModel();

        $display("[TB] reset state");
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_instr_gnt", 32'(instr_gnt_o), 32'h0);
        checkOutput("reset_data_gnt", 32'(data_gnt_o), 32'h0);
        checkOutput("reset_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        checkOutput("reset_data_rvalid", 32'(data_rvalid_o), 32'h0);
        checkOutput("reset_ram_en", 32'(ram_en_o), 32'h0);
        checkOutput("reset_ram_we", 32'(ram_we_o), 32'h0);
        checkOutput("reset_ram_be", 32'(ram_be_o), 32'h0);
        rst_n = 1'b1;

        $display("[TB] instruction-only read");
        doInstr(32'h0000_0180);
        checkOutput("instr_read_rvalid", 32'(instr_rvalid_o), 32'h1);
        checkOutput("instr_read_rdata", instr_rdata_o, 32'h00000013);
        checkOutput("instr_read_data_rvalid", 32'(data_rvalid_o), 32'h0);

        $display("[TB] tie arbitration");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0000_0010, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        end
        idle();

        $display("[TB] byte write and readback");
        doData(1'b1, 4'b0010, 32'h0000_1000, 32'hAABBCCDD);
        doData(1'b0, 4'hF, 32'h0000_1000, 32'h0);
        checkOutput("byte_write_readback", data_rdata_o, 32'h1122CC44);

        $display("[TB] streaming reads and address aliasing");
        doData(1'b0, 4'hF, 32'h0000_0000, 32'h0);
        doData(1'b0, 4'hF, 32'h0000_0004, 32'h0);
        doData(1'b0, 4'hF, 32'h0000_0008, 32'h0);
        doInstr(32'hFFC0_0180);
        checkOutput("alias_rdata", instr_rdata_o, 32'h00000013);
        idle();

        $display("[TB] random traffic");
        p_i = 1'b0;
        p_d = 1'b0;
        p_ia = '0; p_da = '0; p_wd = '0; p_be = '0; p_we = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!p_i && ($urandom_range(0, 9) < 6)) begin
                p_i  = 1'b1;
                p_ia = ($urandom & 32'hFFC0_0000) | (32'($urandom_range(0, 63)) << 2);
            end
            if (!p_d && ($urandom_range(0, 9) < 6)) begin
                p_d  = 1'b1;
                p_we = 1'($urandom_range(0, 1));
                p_be = 4'($urandom_range(1, 15));
                p_da = ($urandom & 32'hFFC0_0000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
                p_wd = $urandom;
            end
            applyStimulus(p_i, p_ia, p_d, p_we, p_be, p_da, p_wd);
            if (e_gi) p_i = 1'b0;
            if (e_gd) p_d = 1'b0;
        end
        idle();

        $display("[TB] reset during an outstanding response");
        doData(1'b0, 4'hF, 32'h0000_0040, 32'h0);
        checkOutput("pre_reset_data_rvalid", 32'(data_rvalid_o), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_data_rvalid", 32'(data_rvalid_o), 32'h0);
        checkOutput("async_reset_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
